// File: rtl/handshake_pkg.sv
// Shared definitions for the valid/ready round-robin arbiter.
package handshake_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int unsigned j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// N-to-1 round-robin arbiter: accepts one beat from the winning master,
// registers it and offers it to a single slave over valid/ready.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          xfer_cnt
);

  state_e              state_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    ptr_d;
  logic [CNT_W-1:0]    cnt_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Pointer moves just past the master that completed, so it gets lowest priority next.
  always_comb begin
    ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  // rst_n gating keeps ready low while reset is asserted, even though state is IDLE.
  assign req_ready = (rst_n && state_q == ST_IDLE) ? pick_grant : '0;
  assign out_valid = (state_q == ST_SEND);
  assign busy      = (state_q == ST_SEND);
  assign out_data  = data_q;
  assign grant_id  = grant_q;
  assign xfer_cnt  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            data_q  <= req_data[pick_idx*DATA_W +: DATA_W];
            grant_q <= pick_idx;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            ptr_q   <= ptr_d;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: constant vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_handshake_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_ready = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic [CW-1:0]   xfer_cnt;

  logic [W-1:0]    mdata [N];
  assign req_data = {mdata[3], mdata[2], mdata[1], mdata[0]};

  always #5 clk = ~clk;

  handshake_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level reference: is a beat held, which one, how many done, who is first in line.
  bit          m_busy;
  logic [W-1:0] m_data;
  int          m_gid, m_cnt, m_ptr;

  typedef struct {
    logic [N-1:0] rv;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_vld;
    logic [1:0]   exp_gid;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_data = '0; m_gid = 0; m_cnt = 0; m_ptr = 0;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic tick();
    int w;
    logic [N-1:0] er;
    #1;
    w  = m_busy ? -1 : winner();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1; m_data = mdata[w]; m_gid = w;
      end
    end else if (out_ready) begin
      m_busy = 1'b0;
      m_cnt  = (m_cnt + 1) % (1 << CW);
      m_ptr  = (m_gid + 1) % N;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_data", out_data, m_data);
    chk("grant_id", 32'(grant_id), m_gid);
    chk("xfer_cnt", 32'(xfer_cnt), m_cnt);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_ready_held", 32'(req_ready), 0);
    chk("rst_busy_held", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    for (int i = 0; i < N; i++) mdata[i] = 32'hA000_0000 | i;

    tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[3]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd1};
    tbl[4]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[5]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd2};
    tbl[6]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[7]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd3};
    tbl[8]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[9]  = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
    tbl[10] = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[11] = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd1};
    tbl[12] = '{4'h8, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[13] = '{4'h2, 1'b1, 4'h0, 1'b0, 2'd3};
    tbl[14] = '{4'h2, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[15] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd1};

    // Reset with every master requesting, then master 0 must win first.
    req_valid = 4'hF;
    out_ready = 1'b0;
    apply_reset();
    tick();
    chk("t1_first_grant", 32'(grant_id), 0);
    chk("t1_first_valid", 32'(out_valid), 1);
    req_valid = '0; out_ready = 1'b1;
    tick();

    // Single master 2.
    apply_reset();
    mdata[2]  = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    tick();
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_gid", 32'(grant_id), 2);
    chk("t2_data", out_data, 32'hDEAD_BEEF);
    req_valid = '0;
    tick();
    chk("t2_cnt", 32'(xfer_cnt), 1);
    mdata[2] = 32'hA000_0002;

    // Full rotation, then wrap-and-skip to master 1.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].rv;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].exp_gid));
    end

    // Backpressure: 5 stalled cycles, single handshake on the sixth.
    req_valid = 4'b0001;
    out_ready = 1'b0;
    tick();
    c0 = m_cnt;
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", out_data, 32'hA000_0000);
      chk("bp_gid", 32'(grant_id), 0);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    chk("bp_cnt_once", 32'(xfer_cnt), 32'(c0 + 1));
    tick();
    chk("bp_cnt_idle_ready", 32'(xfer_cnt), 32'(c0 + 1));

    // Reset while holding a beat.
    mdata[1]  = 32'h1234_5678;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    chk("t6_held", out_data, 32'h1234_5678);
    req_valid = '0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_busy", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdata[1]  = 32'hA000_0001;
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    chk("t6_cnt_zero", 32'(xfer_cnt), 0);
    chk("t6_ptr_zero", 32'(grant_id), 0);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) mdata[$urandom_range(0, N-1)] = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
